// File: rtl/light_bar_pkg.sv
// Shared types and constants for the light-bar mode controller.
// Imported by the interface, the debouncer and the top.
package light_bar_pkg;

  localparam int NUM_PATTERNS = 3;
  localparam int LED_COUNT    = 8;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef logic [1:0] mode_t;

  function automatic mode_t next_mode(input mode_t m);
    return (m == 2'd3) ? 2'd0 : m + 2'd1;
  endfunction

  function automatic logic [NUM_PATTERNS-1:0] mode_onehot(input mode_t m);
    logic [NUM_PATTERNS-1:0] oh;
    oh = '0;
    if (m != 2'd0) oh[m - 2'd1] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/light_mode_ctrl_if.sv
// Bundle between the mode controller and the pattern generators / LED bar.
// master = controller side, slave = generator side.
interface light_mode_ctrl_if;
  import light_bar_pkg::*;

  logic [NUM_PATTERNS*LED_COUNT-1:0] pat_green;
  logic [NUM_PATTERNS*LED_COUNT-1:0] pat_red;
  logic [NUM_PATTERNS-1:0]           pattern_enable;
  logic [LED_COUNT-1:0]              greenLight;
  logic [LED_COUNT-1:0]              redLight;

  modport master (
    input  pat_green,
    input  pat_red,
    output pattern_enable,
    output greenLight,
    output redLight
  );

  modport slave (
    output pat_green,
    output pat_red,
    input  pattern_enable,
    input  greenLight,
    input  redLight
  );

endinterface

// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stable-level debounce counter.
// level follows raw only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce_sync #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] MAX  = '1;

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q >= LAST) begin
        level_d = s2_q;
        cnt_d   = '0;
      end else if (cnt_q != MAX) begin
        cnt_d = cnt_q + CW'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/light_mode_ctrl.sv
// Light-bar mode controller: debounced next/run inputs, mode FSM,
// one-hot generator enables with a blank gap, registered light mux.
module light_mode_ctrl
  import light_bar_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLANK_CYCLES    = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                btn_next,
  input  logic                run_sw,
  light_mode_ctrl_if.master   bar,
  output logic [1:0]          mode
);

  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

  logic btn_db, run_db;
  logic btn_prev_q;
  logic press;

  state_e state_q, state_d;
  mode_t  mode_q, mode_d;
  logic [7:0] blank_q, blank_d;

  logic [NUM_PATTERNS-1:0] en_q, en_d;
  logic [LED_COUNT-1:0]    green_q, green_d;
  logic [LED_COUNT-1:0]    red_q, red_d;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clock (clock),
    .reset (reset),
    .raw   (btn_next),
    .level (btn_db)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .clock (clock),
    .reset (reset),
    .raw   (run_sw),
    .level (run_db)
  );

  assign press = btn_db & ~btn_prev_q;

  // A run-switch fall in RUN takes priority over a coincident press.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    blank_d = '0;
    unique case (state_q)
      OFF: begin
        if (press) begin
          mode_d = 2'd1;
          if (run_db) state_d = BLANK;
        end
      end
      BLANK: begin
        if (blank_q >= BLANK_LAST)
          state_d = (mode_q != 2'd0) ? RUN : OFF;
        else
          blank_d = blank_q + 8'd1;
      end
      RUN: begin
        if (!run_db) begin
          state_d = HOLD;
        end else if (press) begin
          mode_d  = next_mode(mode_q);
          state_d = BLANK;
        end
      end
      HOLD: begin
        if (run_db)     state_d = BLANK;
        else if (press) mode_d  = next_mode(mode_q);
      end
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    en_d    = (state_d == RUN) ? mode_onehot(mode_d) : '0;
    green_d = '0;
    red_d   = '0;
    if (state_q == RUN && state_d == RUN) begin
      unique case (1'b1)
        en_q[0]: begin
          green_d = bar.pat_green[LED_COUNT-1:0];
          red_d   = bar.pat_red[LED_COUNT-1:0];
        end
        en_q[1]: begin
          green_d = bar.pat_green[2*LED_COUNT-1:LED_COUNT];
          red_d   = bar.pat_red[2*LED_COUNT-1:LED_COUNT];
        end
        en_q[2]: begin
          green_d = bar.pat_green[3*LED_COUNT-1:2*LED_COUNT];
          red_d   = bar.pat_red[3*LED_COUNT-1:2*LED_COUNT];
        end
        default: begin
          green_d = '0;
          red_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= OFF;
      mode_q     <= 2'd0;
      blank_q    <= '0;
      btn_prev_q <= 1'b0;
      en_q       <= '0;
      green_q    <= '0;
      red_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      blank_q    <= blank_d;
      btn_prev_q <= btn_db;
      en_q       <= en_d;
      green_q    <= green_d;
      red_q      <= red_d;
    end
  end

  assign bar.pattern_enable = en_q;
  assign bar.greenLight     = green_q;
  assign bar.redLight       = red_q;
  assign mode               = mode_q;

endmodule

// File: tb/tb_light_mode_ctrl.sv
// Bench for light_mode_ctrl: history-based debounce model plus mode
// sequencing model checked every cycle, with directed literal checks.
module tb_light_mode_ctrl;
  import light_bar_pkg::*;

  localparam int DC = 4;
  localparam int BC = 1;

  logic       clock    = 1'b0;
  logic       reset    = 1'b0;
  logic       btn_next = 1'b0;
  logic       run_sw   = 1'b0;
  logic [1:0] mode;

  light_mode_ctrl_if bar();

  light_mode_ctrl #(
    .DEBOUNCE_CYCLES (DC),
    .BLANK_CYCLES    (BC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .btn_next (btn_next),
    .run_sw   (run_sw),
    .bar      (bar),
    .mode     (mode)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Model phases
  localparam int P_OFF = 0, P_BLANK = 1, P_RUN = 2, P_HOLD = 3;

  int          ph, m, bl;
  logic [DC:0] bh, rh;
  logic        bdb, rdb, bprev;
  logic [2:0]  x_en;
  logic [7:0]  x_g, x_r;

  always @(posedge clock or negedge reset) begin : model
    int nph, nm, nbl;
    logic pr;
    if (!reset) begin
      ph <= P_OFF; m <= 0; bl <= 0;
      bh <= '0; rh <= '0;
      bdb <= 1'b0; rdb <= 1'b0; bprev <= 1'b0;
      x_en <= '0; x_g <= '0; x_r <= '0;
    end else begin
      pr  = bdb && !bprev;
      nph = ph; nm = m; nbl = 0;
      case (ph)
        P_OFF: if (pr) begin
          nm = 1;
          if (rdb) nph = P_BLANK;
        end
        P_BLANK: begin
          if (bl >= BC - 1) nph = (m != 0) ? P_RUN : P_OFF;
          else nbl = bl + 1;
        end
        P_RUN: begin
          if (!rdb) nph = P_HOLD;
          else if (pr) begin nm = (m + 1) % 4; nph = P_BLANK; end
        end
        default: begin
          if (rdb) nph = P_BLANK;
          else if (pr) nm = (m + 1) % 4;
        end
      endcase
      if (ph == P_RUN && nph == P_RUN) begin
        x_g <= 8'(bar.pat_green >> (8 * (m - 1)));
        x_r <= 8'(bar.pat_red >> (8 * (m - 1)));
      end else begin
        x_g <= '0;
        x_r <= '0;
      end
      x_en <= (nph == P_RUN) ? 3'(1 << (nm - 1)) : 3'b000;
      ph <= nph; m <= nm; bl <= nbl;
      bprev <= bdb;
      // Accept a new level once the last DC synced samples all disagree.
      if (bdb ? (bh[DC:1] == '0) : (&bh[DC:1])) bdb <= ~bdb;
      if (rdb ? (rh[DC:1] == '0) : (&rh[DC:1])) rdb <= ~rdb;
      bh <= {bh[DC-1:0], btn_next};
      rh <= {rh[DC-1:0], run_sw};
    end
  end

  logic [2:0] prev_en = '0;

  always @(negedge clock) begin
    if (!reset) begin
      prev_en = '0;
    end else begin
      chk("mode", int'(mode), m);
      chk("enable", int'(bar.pattern_enable), int'(x_en));
      chk("greenLight", int'(bar.greenLight), int'(x_g));
      chk("redLight", int'(bar.redLight), int'(x_r));
      chk("onehot", int'($countones(bar.pattern_enable) <= 1), 1);
      chk("blank_gap",
          int'(prev_en != 0 && bar.pattern_enable != 0 &&
               bar.pattern_enable != prev_en), 0);
      prev_en = bar.pattern_enable;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_btn();
    btn_next = 1'b1;
    cyc(8);
    btn_next = 1'b0;
    cyc(8);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_mode [4];
    int exp_en   [4];
    bit seen;
    exp_mode = '{1, 2, 3, 0};
    exp_en   = '{1, 2, 4, 0};
    bar.pat_green = 24'h3C5AA5;
    bar.pat_red   = 24'h814218;

    cyc(2);
    chk("rst_mode", int'(mode), 0);
    chk("rst_en", int'(bar.pattern_enable), 0);
    chk("rst_green", int'(bar.greenLight), 0);
    chk("rst_red", int'(bar.redLight), 0);
    reset  = 1'b1;
    run_sw = 1'b1;
    cyc(10);

    // Held button: exactly one press, one blank cycle, then mode 1
    seen = 1'b0;
    btn_next = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (!seen && mode == 2'd1) begin
        seen = 1'b1;
        chk("t2_blank_en", int'(bar.pattern_enable), 0);
      end
    end
    chk("t2_seen_mode1", int'(seen), 1);
    chk("t2_mode", int'(mode), 1);
    chk("t2_en", int'(bar.pattern_enable), 1);
    chk("t2_green", int'(bar.greenLight), 'hA5);
    chk("t2_red", int'(bar.redLight), 'h18);
    btn_next = 1'b0;
    cyc(10);

    // Bounce: never stable for DC cycles
    for (int i = 0; i < 5; i++) begin
      btn_next = 1'b1; cyc(2);
      btn_next = 1'b0; cyc(2);
    end
    cyc(8);
    chk("t3_mode", int'(mode), 1);
    chk("t3_en", int'(bar.pattern_enable), 1);

    // Walk to OFF, then four clean presses
    repeat (3) press_btn();
    chk("t4_off_mode", int'(mode), 0);
    chk("t4_off_en", int'(bar.pattern_enable), 0);
    for (int i = 0; i < 4; i++) begin
      press_btn();
      chk("t4_mode", int'(mode), exp_mode[i]);
      chk("t4_en", int'(bar.pattern_enable), exp_en[i]);
    end

    // Mode 3, then drop and raise run switch
    repeat (3) press_btn();
    chk("t5_mode3", int'(mode), 3);
    chk("t5_en3", int'(bar.pattern_enable), 4);
    chk("t5_green3", int'(bar.greenLight), 'h3C);
    chk("t5_red3", int'(bar.redLight), 'h81);
    run_sw = 1'b0;
    cyc(10);
    chk("t5_hold_en", int'(bar.pattern_enable), 0);
    chk("t5_hold_green", int'(bar.greenLight), 0);
    chk("t5_hold_red", int'(bar.redLight), 0);
    chk("t5_hold_mode", int'(mode), 3);
    run_sw = 1'b1;
    cyc(10);
    chk("t5_resume_en", int'(bar.pattern_enable), 4);
    chk("t5_resume_green", int'(bar.greenLight), 'h3C);

    // Coincident press and run fall in mode 1
    repeat (2) press_btn();
    chk("t6_mode1", int'(mode), 1);
    btn_next = 1'b1;
    run_sw   = 1'b0;
    cyc(10);
    chk("t6_mode", int'(mode), 1);
    chk("t6_en", int'(bar.pattern_enable), 0);
    chk("t6_green", int'(bar.greenLight), 0);
    btn_next = 1'b0;
    cyc(8);
    run_sw = 1'b1;
    cyc(10);
    chk("t6_resume_en", int'(bar.pattern_enable), 1);

    // Asynchronous reset while running mode 2
    press_btn();
    chk("t1_pre_mode", int'(mode), 2);
    chk("t1_pre_en", int'(bar.pattern_enable), 2);
    #2 reset = 1'b0;
    #1;
    chk("t1_en", int'(bar.pattern_enable), 0);
    chk("t1_green", int'(bar.greenLight), 0);
    chk("t1_red", int'(bar.redLight), 0);
    chk("t1_mode", int'(mode), 0);
    cyc(2);
    #2 reset = 1'b1;
    cyc(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_mode_ctrl.md
Name: light_mode_ctrl

Overview:
- Upstream controller for the light-bar pattern generators. It debounces a front-panel "next" button and a run switch, then steps through OFF and three pattern modes.
- Drives a one-hot enable to each pattern generator. The generators reset on the falling edge of their enable.
- Muxes the selected generator's green/red vectors onto the light-bar outputs.
- Guarantees at least one blank cycle with all enables low on every mode change, so the generators always restart from their initial frame.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable clock cycles required to accept a new button/switch level (10 ms at 50 MHz).
- BLANK_CYCLES, 1: cycles spent in BLANK (all enables low, lights off) between modes; legal range 1..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; resets all state.
- btn_next  in  1  raw asynchronous pushbutton, active-high.
- run_sw  in  1  raw asynchronous run switch, active-high.
- pat_green  in  24  green vectors of generators 1..3; bits [7:0] = gen1, [15:8] = gen2, [23:16] = gen3.
- pat_red  in  24  red vectors, same packing as pat_green.
- pattern_enable  out  3  one-hot enable; bit k-1 drives generator k; all-zero when not running.
- greenLight  out  8  green LED drive; bit 7 = leftmost LED.
- redLight  out  8  red LED drive; same bit order as greenLight.
- mode  out  2  current mode: 0 = OFF, 1..3 = pattern number.

Behaviour:
- Reset (reset = 0), asynchronous:
  - mode = 0, state = OFF, pattern_enable = 3'b000, greenLight = redLight = 8'h00.
  - Debounced button = 0, debounced switch = 0, debounce counters = 0.
- Synchronisation: btn_next and run_sw each pass through a 2-flop synchroniser before any other logic.
- Debounce, one counter per input:
  - If the synced value differs from the debounced value, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES - 1 while still differing, the debounced value takes the synced value and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES) + 1 and saturates; no wrap.
- press: single-cycle pulse on a 0 -> 1 transition of the debounced button.
- FSM states:
  - OFF: enables 0, lights 0.
    - press with run_sw_db = 1 -> mode = 1, go to BLANK.
    - press with run_sw_db = 0 -> mode = 1, stay in OFF (armed, not running).
  - BLANK: enables 0, lights 0; counts BLANK_CYCLES cycles.
    - At expiry -> RUN if mode != 0, else OFF.
    - press during BLANK is ignored.
  - RUN: pattern_enable = one-hot of mode.
    - press -> mode = (mode == 3) ? 0 : mode + 1, go to BLANK.
    - run_sw_db falls -> go to HOLD; mode retained.
  - HOLD: enables 0, lights 0.
    - run_sw_db rises -> BLANK, then RUN with the retained mode.
    - press -> advance mode as in RUN, stay in HOLD.
- Simultaneous press and run_sw_db fall in RUN: the fall wins; go to HOLD with mode unchanged.
- Light outputs are registered, one cycle of latency:
  - In RUN, greenLight/redLight in cycle n+1 equal the selected pat_green/pat_red slice sampled in cycle n.
  - In any other state they are forced to 0.
- pattern_enable is a direct registered decode of state and mode; it is never multi-hot.
- The mode sequence wraps 3 -> 0 (OFF); from OFF a press always goes to 1.

Decomposition:
- Shared package light_bar_pkg:
  - State encoding constants: OFF = 2'd0, BLANK = 2'd1, RUN = 2'd2, HOLD = 2'd3.
  - NUM_PATTERNS = 3.
  - LED_COUNT = 8.
- Sub-module debounce_sync: synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES, ports clock/reset/raw/level. Instantiated twice.

Test Plan (DEBOUNCE_CYCLES = 4, BLANK_CYCLES = 1):
1. Reset asserted mid-RUN with mode = 2 -> same cycle: pattern_enable = 000, greenLight = redLight = 00, mode = 0.
2. run_sw = 1, btn_next held 10 cycles -> exactly one press:
   - mode = 1; one BLANK cycle with enable = 000; then enable = 001.
   - With pat_green[7:0] = 8'hA5, greenLight = 8'hA5 one cycle after RUN is entered.
3. btn_next toggled every 2 cycles for 20 cycles (bounce) -> no press; mode and enables unchanged.
4. Four clean presses from OFF with run_sw = 1:
   - mode goes 1, 2, 3, 0; enables 001, 010, 100, 000.
   - Each transition has at least one cycle of 000 before the new enable appears.
5. In RUN mode 3, run_sw dropped -> after debounce: enables 000, lights 00, mode = 3. Raise run_sw -> after debounce: BLANK then enable = 100.
6. Press and run_sw fall debounced in the same cycle while in RUN mode 1 -> HOLD, mode = 1, enables 000.
